// File: rtl/elbeth_dmem_interface_if.sv
// Data-memory access bundle: EXS-stage request side and data-bus side.
// slave = access unit view, master = pipeline/bus-model view.
interface elbeth_dmem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  exs_mem_en;
    logic                  exs_mem_rw;
    logic [1:0]            exs_mem_size;
    logic                  exs_mem_sign;
    logic [ADDR_WIDTH-1:0] exs_addr;
    logic [31:0]           exs_wdata;
    logic                  exs_stall;
    logic [31:0]           exs_rdata;
    logic                  exs_dmem_en;
    logic                  exs_dmem_ready;
    logic                  exs_exception;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]           dmem_wdata;
    logic [3:0]            dmem_wsel;
    logic                  dmem_we;
    logic                  dmem_en;
    logic [31:0]           dmem_rdata;
    logic                  dmem_ack;

    modport slave (
        input  exs_mem_en, exs_mem_rw, exs_mem_size, exs_mem_sign,
        input  exs_addr, exs_wdata, exs_stall,
        output exs_rdata, exs_dmem_en, exs_dmem_ready, exs_exception,
        output dmem_addr, dmem_wdata, dmem_wsel, dmem_we, dmem_en,
        input  dmem_rdata, dmem_ack
    );

    modport master (
        output exs_mem_en, exs_mem_rw, exs_mem_size, exs_mem_sign,
        output exs_addr, exs_wdata, exs_stall,
        input  exs_rdata, exs_dmem_en, exs_dmem_ready, exs_exception,
        input  dmem_addr, dmem_wdata, dmem_wsel, dmem_we, dmem_en,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/elbeth_dmem_interface.sv
// EXS-stage data-memory access unit: req/ack bus cycle, lane steering, load extend.
// Optional ELBETH_DMEM_MISALIGN_EXC_EN: trap misaligned accesses instead of truncating.
module elbeth_dmem_interface #(
    parameter int ADDR_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    elbeth_dmem_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  w_a;
    logic [1:0]  w_a_eff;
    logic        w_issue;
    logic        w_trap;
    logic [3:0]  w_wsel;
    logic [31:0] w_wdata;

    logic        r_rw;
    logic        r_sign;
    logic [1:0]  r_size;
    logic [1:0]  r_a;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldata;

    assign w_a = bus.exs_addr[1:0];

    // Natural-alignment lane offset; misaligned offsets fold onto it.
    always_comb begin
        w_a_eff = w_a;
        unique case (bus.exs_mem_size)
            2'b00:   w_a_eff = w_a;
            2'b01:   w_a_eff = {w_a[1], 1'b0};
            default: w_a_eff = 2'b00;
        endcase
    end

`ifdef ELBETH_DMEM_MISALIGN_EXC_EN
    logic w_misalign;
    logic r_exc;

    always_comb begin
        w_misalign = 1'b0;
        unique case (bus.exs_mem_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = w_a[0];
            default: w_misalign = |w_a;
        endcase
    end

    assign w_trap  = (r_state == IDLE) & bus.exs_mem_en & w_misalign;
    assign w_issue = (r_state == IDLE) & bus.exs_mem_en & ~w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_exc <= 1'b0;
        else     r_exc <= (w_next == DONE) & (w_trap | r_exc);
    end

    assign bus.exs_exception = r_exc;
`else
    assign w_trap  = 1'b0;
    assign w_issue = (r_state == IDLE) & bus.exs_mem_en;

    assign bus.exs_exception = 1'b0;
`endif

    always_comb begin
        w_wsel  = 4'b1111;
        w_wdata = bus.exs_wdata;
        unique case (bus.exs_mem_size)
            2'b00: begin
                w_wsel  = 4'b0001 << w_a_eff;
                w_wdata = {4{bus.exs_wdata[7:0]}};
            end
            2'b01: begin
                w_wsel  = w_a_eff[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.exs_wdata[15:0]}};
            end
            default: begin
                w_wsel  = 4'b1111;
                w_wdata = bus.exs_wdata;
            end
        endcase
        if (!bus.exs_mem_rw) w_wsel = 4'b1111;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_issue)     w_next = BUSY;
                else if (w_trap) w_next = DONE;
            end
            BUSY:    if (bus.dmem_ack) w_next = DONE;
            DONE:    if (!bus.exs_stall) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_byte = bus.dmem_rdata[8*r_a +: 8];
    assign w_half = r_a[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

    always_comb begin
        w_ldata = bus.dmem_rdata;
        unique case (r_size)
            2'b00:   w_ldata = {{24{r_sign & w_byte[7]}}, w_byte};
            2'b01:   w_ldata = {{16{r_sign & w_half[15]}}, w_half};
            default: w_ldata = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            bus.dmem_wsel  <= '0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_en    <= 1'b0;
            bus.exs_rdata  <= '0;
            r_rw           <= 1'b0;
            r_sign         <= 1'b0;
            r_size         <= 2'b00;
            r_a            <= 2'b00;
        end else if (w_issue) begin
            bus.dmem_addr  <= {bus.exs_addr[ADDR_WIDTH-1:2], 2'b00};
            bus.dmem_wdata <= w_wdata;
            bus.dmem_wsel  <= w_wsel;
            bus.dmem_we    <= bus.exs_mem_rw;
            bus.dmem_en    <= 1'b1;
            r_rw           <= bus.exs_mem_rw;
            r_sign         <= bus.exs_mem_sign;
            r_size         <= bus.exs_mem_size;
            r_a            <= w_a_eff;
        end else if ((r_state == BUSY) && bus.dmem_ack) begin
            bus.dmem_en <= 1'b0;
            bus.dmem_we <= 1'b0;
            if (!r_rw) bus.exs_rdata <= w_ldata;
        end
    end

    assign bus.exs_dmem_en    = ((r_state == IDLE) & bus.exs_mem_en)
                              | (r_state != IDLE);
    assign bus.exs_dmem_ready = (r_state == DONE);

endmodule

// File: tb/tb_elbeth_dmem_interface.sv
// Randomized self-checking bench for elbeth_dmem_interface.
// Reference model computes lanes and load results arithmetically.
module tb_elbeth_dmem_interface;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    elbeth_dmem_if #(.ADDR_WIDTH(32)) u_if ();

    elbeth_dmem_interface #(.ADDR_WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int          n_tot = 0;
    int          n_bad = 0;
    logic [31:0] exp_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lane_of(input int size, input int a);
        if (size == 0) return a;
        if (size == 1) return (a / 2) * 2;
        return 0;
    endfunction

    function automatic logic [31:0] m_wsel(input int rw, input int size,
                                           input int a);
        if (rw == 0)   return 32'd15;
        if (size == 0) return 32'(1 << a);
        if (size == 1) return (a >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input int size,
                                            input logic [31:0] w);
        if (size == 0) return (w % 256) * 32'h01010101;
        if (size == 1) return (w % 65536) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input int size, input int sign,
                                           input int a, input logic [31:0] r);
        logic [31:0] v;
        if (size == 0) begin
            v = (r >> (8 * a)) % 256;
            if (sign != 0 && v >= 128) v = v + 32'hFFFFFF00;
            return v;
        end
        if (size == 1) begin
            v = (r >> (8 * a)) % 65536;
            if (sign != 0 && v >= 32768) v = v + 32'hFFFF0000;
            return v;
        end
        return r;
    endfunction

    task automatic txn(input int rw, input int size, input int sign,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int wt, input int st);
        int a;
        a = lane_of(size, int'(addr[1:0]));
        @(negedge clk);
        u_if.exs_mem_en   = 1'b1;
        u_if.exs_mem_rw   = rw[0];
        u_if.exs_mem_size = size[1:0];
        u_if.exs_mem_sign = sign[0];
        u_if.exs_addr     = addr;
        u_if.exs_wdata    = wd;
        #1;
        chk("req_exs_en", u_if.exs_dmem_en, 1);
        chk("req_rdy", u_if.exs_dmem_ready, 0);
        @(negedge clk);
        u_if.exs_mem_en = 1'b0;
        chk("busy_en", u_if.dmem_en, 1);
        chk("busy_addr", u_if.dmem_addr, addr & 32'hFFFFFFFC);
        chk("busy_wsel", u_if.dmem_wsel, m_wsel(rw, size, a));
        chk("busy_we", u_if.dmem_we, rw);
        if (rw != 0) chk("busy_wdata", u_if.dmem_wdata, m_wdata(size, wd));
        for (int i = 0; i < wt; i++) begin
            u_if.dmem_ack = 1'b0;
            @(negedge clk);
            chk("wait_en", u_if.dmem_en, 1);
            chk("wait_exs_en", u_if.exs_dmem_en, 1);
            chk("wait_rdy", u_if.exs_dmem_ready, 0);
        end
        u_if.dmem_ack   = 1'b1;
        u_if.dmem_rdata = rd;
        @(negedge clk);
        u_if.dmem_ack   = 1'b0;
        u_if.dmem_rdata = $urandom;
        if (rw == 0) exp_rdata = m_load(size, sign, a, rd);
        chk("done_rdy", u_if.exs_dmem_ready, 1);
        chk("done_en", u_if.dmem_en, 0);
        chk("done_we", u_if.dmem_we, 0);
        chk("done_exc", u_if.exs_exception, 0);
        chk("done_rdata", u_if.exs_rdata, exp_rdata);
        for (int i = 0; i < st; i++) begin
            u_if.exs_stall = 1'b1;
            u_if.dmem_ack  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_rdy", u_if.exs_dmem_ready, 1);
            chk("stall_en", u_if.dmem_en, 0);
        end
        u_if.exs_stall = 1'b0;
        u_if.dmem_ack  = 1'b0;
        @(negedge clk);
        chk("idle_rdy", u_if.exs_dmem_ready, 0);
        chk("idle_en", u_if.dmem_en, 0);
        chk("idle_rdata", u_if.exs_rdata, exp_rdata);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", n_tot, n_bad);
        $fatal(1);
    end

    initial begin
        int          rw;
        int          size;
        int          sign;
        logic [31:0] addr;

        rst               = 1'b1;
        u_if.exs_mem_en   = 1'b0;
        u_if.exs_mem_rw   = 1'b0;
        u_if.exs_mem_size = 2'b00;
        u_if.exs_mem_sign = 1'b0;
        u_if.exs_addr     = '0;
        u_if.exs_wdata    = '0;
        u_if.exs_stall    = 1'b0;
        u_if.dmem_rdata   = '0;
        u_if.dmem_ack     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_en", u_if.dmem_en, 0);
        chk("rst_we", u_if.dmem_we, 0);
        chk("rst_wsel", u_if.dmem_wsel, 0);
        chk("rst_addr", u_if.dmem_addr, 0);
        chk("rst_wdata", u_if.dmem_wdata, 0);
        chk("rst_rdata", u_if.exs_rdata, 0);
        chk("rst_rdy", u_if.exs_dmem_ready, 0);
        chk("rst_exc", u_if.exs_exception, 0);
        chk("rst_exs_en", u_if.exs_dmem_en, 0);

        // Reset in the middle of a bus cycle, then a stale ack.
        @(negedge clk);
        u_if.exs_mem_en   = 1'b1;
        u_if.exs_mem_size = 2'b10;
        u_if.exs_addr     = 32'h300;
        @(negedge clk);
        u_if.exs_mem_en = 1'b0;
        chk("mid_en", u_if.dmem_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_en", u_if.dmem_en, 0);
        chk("arst_rdy", u_if.exs_dmem_ready, 0);
        @(negedge clk);
        rst             = 1'b0;
        u_if.dmem_ack   = 1'b1;
        u_if.dmem_rdata = 32'h12345678;
        @(negedge clk);
        u_if.dmem_ack = 1'b0;
        chk("late_ack_en", u_if.dmem_en, 0);
        chk("late_ack_rdy", u_if.exs_dmem_ready, 0);
        chk("late_ack_rdata", u_if.exs_rdata, 0);
        chk("late_ack_exs_en", u_if.exs_dmem_en, 0);

        txn(0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        txn(0, 0, 1, 32'h103, 32'h0, 32'h80123456, 0, 0);
        txn(0, 0, 0, 32'h103, 32'h0, 32'h80123456, 1, 0);
        txn(1, 1, 0, 32'h202, 32'h0000ABCD, 32'h0, 3, 0);
        txn(0, 1, 1, 32'h402, 32'h0, 32'h9ABC1234, 0, 2);
        txn(1, 0, 0, 32'h501, 32'h000000A5, 32'h0, 2, 2);

`ifdef ELBETH_DMEM_MISALIGN_EXC_EN
        @(negedge clk);
        u_if.exs_mem_en   = 1'b1;
        u_if.exs_mem_rw   = 1'b0;
        u_if.exs_mem_size = 2'b10;
        u_if.exs_addr     = 32'h101;
        #1;
        chk("mis_exs_en", u_if.exs_dmem_en, 1);
        @(negedge clk);
        u_if.exs_mem_en = 1'b0;
        chk("mis_en", u_if.dmem_en, 0);
        chk("mis_rdy", u_if.exs_dmem_ready, 1);
        chk("mis_exc", u_if.exs_exception, 1);
        chk("mis_rdata", u_if.exs_rdata, exp_rdata);
        @(negedge clk);
        chk("mis_exc_clr", u_if.exs_exception, 0);
        chk("mis_rdy_clr", u_if.exs_dmem_ready, 0);
`else
        txn(0, 2, 0, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0);
        txn(0, 1, 1, 32'h203, 32'h0, 32'h8001F00D, 1, 0);
`endif

        for (int k = 0; k < 60; k++) begin
            rw   = int'($urandom_range(0, 1));
            size = int'($urandom_range(0, 3));
            sign = int'($urandom_range(0, 1));
            addr = $urandom;
`ifdef ELBETH_DMEM_MISALIGN_EXC_EN
            if (size == 1) addr = addr & 32'hFFFFFFFE;
            if (size >= 2) addr = addr & 32'hFFFFFFFC;
`endif
            txn(rw, size, sign, addr, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/elbeth_dmem_interface.md
Name: elbeth_dmem_interface

Overview:
Data-memory access unit of the EXS stage. It sits between the pipeline datapath/control unit and the data-memory bus.
- Takes load/store requests from the EXS stage (enable, rw, size, sign, address, write data).
- Runs a request/acknowledge transaction on the data bus with byte-lane steering.
- Returns aligned, sign/zero-extended load data.
- Produces exs_dmem_en / exs_dmem_ready, which the control unit uses to stall the pipeline.

Parameters:
ADDR_WIDTH, 32, width of exs_addr and dmem_addr (data path fixed at 32 bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
exs_mem_en  input  1  EXS instruction is a load/store
exs_mem_rw  input  1  1 = store, 0 = load
exs_mem_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
exs_mem_sign  input  1  1 = sign-extend load data, 0 = zero-extend
exs_addr  input  ADDR_WIDTH  byte address
exs_wdata  input  32  store data (right-justified)
exs_stall  input  1  pipeline held by another stall source; hold completion
exs_rdata  output  32  load result, registered
exs_dmem_en  output  1  access in progress for current EXS instruction (to control unit)
exs_dmem_ready  output  1  access complete (to control unit)
exs_exception  output  1  misaligned access (only with optional feature)
dmem_addr  output  ADDR_WIDTH  word address {exs_addr[ADDR_WIDTH-1:2],2'b00}, registered
dmem_wdata  output  32  lane-replicated store data, registered
dmem_wsel  output  4  byte-lane enables, registered
dmem_we  output  1  write strobe, registered
dmem_en  output  1  bus request, registered
dmem_rdata  input  32  bus read data
dmem_ack  input  1  bus acknowledge, valid when dmem_en=1

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - dmem_en, dmem_we, exs_dmem_ready and exs_exception = 0.
  - dmem_wsel=0, dmem_addr=0, dmem_wdata=0, exs_rdata=0.
  - Reset mid-transaction drops dmem_en immediately; a late dmem_ack after reset is ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: when exs_mem_en=1 (and aligned), latch request, drive bus registers and go to BUSY; dmem_en=1 from the next cycle. Otherwise stay in IDLE.
  - BUSY: dmem_en=1, with dmem_addr/wdata/wsel/we held stable. On dmem_ack=1, capture the load result into exs_rdata (stores leave exs_rdata unchanged), drop dmem_en and dmem_we in the same edge, and go to DONE.
  - DONE: exs_dmem_ready=1. If exs_stall=0, go to IDLE next cycle; if exs_stall=1, stay in DONE with ready held so the held instruction is not re-issued.
- exs_dmem_en (combinational) = (IDLE & exs_mem_en) | BUSY | DONE.
  - The control unit stall term is exs_dmem_en & ~exs_dmem_ready.
- Minimum latency with zero-wait bus (ack in first BUSY cycle): request seen in IDLE at cycle 0, BUSY at cycle 1, ready at cycle 2.
- dmem_ack outside BUSY is ignored.
- Store lanes, with a = exs_addr[1:0]:
  - byte: wsel = 4'b0001<<a, wdata = {4{wdata[7:0]}}
  - half: wsel = a[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}
  - word: wsel = 1111
  - Loads: wsel=1111, we=0.
- Load extraction: byte from lane a, half from lane a[1], word as-is; extend to 32 bits per exs_mem_sign (ignored for word).
- Misalignment: half with a[0]=1, or word with a!=00.

Optional Feature:
ELBETH_DMEM_MISALIGN_EXC_EN
- Defined: a misaligned request in IDLE issues no bus cycle and goes straight to DONE.
  - exs_exception=1 and exs_dmem_ready=1 while in DONE; exs_rdata unchanged.
  - exs_exception clears on leaving DONE.
- Undefined: exs_exception tied 0; misaligned addresses are truncated to natural alignment (half clears a[0], word clears a[1:0]) and proceed normally.

Test Plan:
- Load word: addr=0x100, dmem_rdata=0xDEADBEEF, ack in 1st BUSY cycle -> dmem_addr=0x100, wsel=1111, we=0; ready at cycle 2; exs_rdata=0xDEADBEEF.
- Signed byte load: addr=0x103, rdata=0x80123456, sign=1 -> exs_rdata=0xFFFFFF80. Same with sign=0 -> 0x00000080.
- Store half: addr=0x202, wdata=0x0000ABCD, ack delayed 3 cycles -> dmem_en held 4 cycles; wsel=1100; dmem_wdata=0xABCDABCD; exs_dmem_en=1 and ready=0 throughout BUSY.
- Completion under exs_stall=1 for 2 cycles after ack -> DONE held, ready=1 for 3 cycles, no second dmem_en pulse.
- rst asserted in BUSY, then ack arrives -> dmem_en=0 asynchronously, state IDLE, exs_rdata stays 0.
- Word load at addr=0x101: with macro -> no dmem_en, exs_exception=1 and ready=1 at cycle 1. Without macro -> dmem_addr=0x100, normal access.
